rvfi_reg_sweep_ctrl: RTL and testbench
======================================

// Module: rvfi_reg_sweep_ctrl
// PURPOSE
// Sequences a single-register RVFI shadow checker across architectural registers x1..x31 on ibex_top.
// Holds one target register at a time and shadows its last retired write.
// Checks every retired rs1/rs2 read of the target against the shadow.
// Advances to the next register after enough checks or a timeout, so one comparator covers the whole file.
// PARAMETERS
// CHECKS_PER_REG  4   checked reads of the target before advancing (>=1)
// TIMEOUT         64  retirements without progress before forced advance (>=1)
// FIRST_REG       1   target after reset (1..31; x0 is never targeted)
// PORTS
// clk_i           in   1   clock
// rst_ni          in   1   synchronous active-low reset
// rvfi_valid      in   1   retirement valid
// rvfi_rd_addr    in   5   retired rd index
// rvfi_rd_wdata   in   32  retired rd write data
// rvfi_rs1_addr   in   5   retired rs1 index
// rvfi_rs1_rdata  in   32  retired rs1 read data
// rvfi_rs2_addr   in   5   retired rs2 index
// rvfi_rs2_rdata  in   32  retired rs2 read data
// tgt_addr_o      out  5   current target register
// tgt_written_o   out  1   shadow valid (FSM in TRACK)
// tgt_data_o      out  32  shadow of the target's last write
// err_rs1_o       out  1   1-cycle pulse: rs1 read of target mismatched shadow
// err_rs2_o       out  1   1-cycle pulse: rs2 read of target mismatched shadow
// err_sticky_o    out  1   set on any mismatch, cleared only by reset
// sweep_done_o    out  1   1-cycle pulse when target wraps 31->1
// BEHAVIOUR
// Reset (rst_ni=0 at posedge) gives:
//   - state ARM, tgt_addr_o=FIRST_REG, tgt_data_o=0, all other outputs 0.
//   - Check and timeout counters cleared. Reset mid-operation discards the shadow entirely.
// "ret" means rvfi_valid=1 at a posedge. Signals with valid=0 are ignored.
// hit1 = rs1_addr==tgt. hit2 = rs2_addr==tgt. wr = rd_addr==tgt.
// ARM (tgt_written_o=0):
//   - ret with wr: data<=rd_wdata, then TRACK. Check and timeout counters clear.
//   - ret without wr: timeout++. Reaching TIMEOUT moves to ADVANCE.
//   - Reads of the target in ARM are not compared.
// TRACK (tgt_written_o=1):
//   - ret with hit1 or hit2: compare against the OLD shadow.
//   - A mismatch on rs1 asserts err_rs1_o on the next cycle. rs2 likewise asserts err_rs2_o.
//   - err_sticky_o is set on either mismatch.
//   - One ret counts as ONE check even when both hit1 and hit2. The check also clears timeout.
//   - ret with wr: data<=rd_wdata, applied after the compare. A read+write of the target in the same ret checks the pre-write value.
//   - ret with no hit: timeout++.
//   - check count reaching CHECKS_PER_REG, or timeout reaching TIMEOUT, moves to ADVANCE.
//   - The final check's compare still completes.
// ADVANCE (exactly 1 cycle, ret ignored):
//   - tgt <= (tgt==31) ? 1 : tgt+1. sweep_done_o pulses in the cycle after the 31->1 wrap.
//   - Shadow is invalidated and counters are cleared, then ARM.
// Counter widths: $clog2(CHECKS_PER_REG+1) and $clog2(TIMEOUT+1). Both saturate; they never wrap.
// Writes to x0 are never shadowed because x0 is never a target.
// err_* outputs are registered. Latency is 1 cycle from the mismatching ret.
// TESTING
// 1. After reset: ret rd=x1 wdata=0xDEADBEEF, then ret rs1=x1 rdata=0xDEADBEEF.
//    -> tgt_written_o=1, tgt_data_o=0xDEADBEEF, no err.
// 2. In TRACK on x1 (shadow 0xDEADBEEF): ret rs2=x1 rdata=0x0.
//    -> err_rs2_o pulses 1 cycle later, err_sticky_o stays 1, err_rs1_o=0.
// 3. Four checked reads of x1 (CHECKS_PER_REG=4).
//    -> ADVANCE, tgt_addr_o=2 and tgt_written_o=0 two cycles after the 4th ret.
// 4. 64 rets never touching the target in ARM.
//    -> forced ADVANCE. Sweep from 31 wraps to 1 with a sweep_done_o pulse.
// 5. Shadow 0x11; ret rs1=x1 rdata=0x11 with rd=x1 wdata=0x22.
//    -> no err, tgt_data_o=0x22, check count +1.
// 6. Reset asserted mid-TRACK on x5.
//    -> tgt_addr_o=FIRST_REG, tgt_written_o=0, err_sticky_o=0 the next cycle.

Source files
------------

// File: rtl/rvfi_reg_sweep_ctrl.sv
// RVFI single-register shadow checker sequencer: shadows one target register's
// last retired write, checks retired reads of it, and sweeps targets x1..x31.
module rvfi_reg_sweep_ctrl #(
  parameter int unsigned CHECKS_PER_REG = 4,
  parameter int unsigned TIMEOUT        = 64,
  parameter int unsigned FIRST_REG      = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rvfi_valid,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [4:0]  rvfi_rs1_addr,
  input  logic [31:0] rvfi_rs1_rdata,
  input  logic [4:0]  rvfi_rs2_addr,
  input  logic [31:0] rvfi_rs2_rdata,
  output logic [4:0]  tgt_addr_o,
  output logic        tgt_written_o,
  output logic [31:0] tgt_data_o,
  output logic        err_rs1_o,
  output logic        err_rs2_o,
  output logic        err_sticky_o,
  output logic        sweep_done_o
);

  localparam int unsigned CW = (CHECKS_PER_REG < 1) ? 1 : $clog2(CHECKS_PER_REG + 1);
  localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CHK_MAX = CW'(CHECKS_PER_REG);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
  localparam logic [4:0]    TGT_RST = 5'(FIRST_REG);

  typedef enum logic [1:0] {ARM, TRACK, ADVANCE} state_e;

  state_e        state_q, state_d;
  logic [4:0]    tgt_q, tgt_d;
  logic [31:0]   data_q, data_d;
  logic [CW-1:0] chk_q, chk_d, chk_inc;
  logic [TW-1:0] to_q, to_d, to_inc;
  logic          err1_q, err1_d, err2_q, err2_d;
  logic          sticky_q, sticky_d, done_q, done_d;
  logic          hit1, hit2, wr;

  assign hit1    = rvfi_rs1_addr == tgt_q;
  assign hit2    = rvfi_rs2_addr == tgt_q;
  assign wr      = rvfi_rd_addr == tgt_q;
  assign chk_inc = (chk_q == CHK_MAX) ? chk_q : chk_q + 1'b1;
  assign to_inc  = (to_q == TO_MAX) ? to_q : to_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    data_d   = data_q;
    chk_d    = chk_q;
    to_d     = to_q;
    err1_d   = 1'b0;
    err2_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      ARM: begin
        if (rvfi_valid) begin
          if (wr) begin
            data_d  = rvfi_rd_wdata;
            chk_d   = '0;
            to_d    = '0;
            state_d = TRACK;
          end else begin
            to_d = to_inc;
            if (to_inc >= TO_MAX) state_d = ADVANCE;
          end
        end
      end
      TRACK: begin
        if (rvfi_valid) begin
          // compare uses the shadow as it was before this retirement's write
          err1_d = hit1 && (rvfi_rs1_rdata != data_q);
          err2_d = hit2 && (rvfi_rs2_rdata != data_q);
          if (hit1 || hit2) begin
            chk_d = chk_inc;
            to_d  = '0;
          end else begin
            to_d = to_inc;
          end
          if (wr) data_d = rvfi_rd_wdata;
          if (chk_d >= CHK_MAX || to_d >= TO_MAX) state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        tgt_d   = (tgt_q == 5'd31) ? 5'd1 : tgt_q + 5'd1;
        done_d  = tgt_q == 5'd31;
        data_d  = '0;
        chk_d   = '0;
        to_d    = '0;
        state_d = ARM;
      end
      default: state_d = ARM;
    endcase
    sticky_d = sticky_q | err1_d | err2_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ARM;
      tgt_q    <= TGT_RST;
      data_q   <= '0;
      chk_q    <= '0;
      to_q     <= '0;
      err1_q   <= 1'b0;
      err2_q   <= 1'b0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      data_q   <= data_d;
      chk_q    <= chk_d;
      to_q     <= to_d;
      err1_q   <= err1_d;
      err2_q   <= err2_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
    end
  end

  assign tgt_addr_o    = tgt_q;
  assign tgt_written_o = state_q == TRACK;
  assign tgt_data_o    = data_q;
  assign err_rs1_o     = err1_q;
  assign err_rs2_o     = err2_q;
  assign err_sticky_o  = sticky_q;
  assign sweep_done_o  = done_q;

endmodule

// File: tb/tb_rvfi_reg_sweep_ctrl.sv
// Self-checking bench for rvfi_reg_sweep_ctrl: directed scenarios plus randomized
// retirements compared against a behavioural shadow-checker model.
module tb_rvfi_reg_sweep_ctrl;

  localparam int CHECKS = 4;
  localparam int TMO    = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [4:0]  rd_addr = '0, rs1_addr = '0, rs2_addr = '0;
  logic [31:0] rd_wdata = '0, rs1_rdata = '0, rs2_rdata = '0;
  logic [4:0]  tgt_addr;
  logic        tgt_written, err_rs1, err_rs2, err_sticky, sweep_done;
  logic [31:0] tgt_data;

  int passed = 0;
  int total  = 0;

  // behavioural model: target, shadow-valid flag, pending advance, counts
  int          m_tgt = 1;
  bit          m_valid = 0, m_adv = 0, m_e1 = 0, m_e2 = 0, m_sticky = 0, m_done = 0;
  logic [31:0] m_data = '0;
  int          m_checks = 0, m_idle = 0;

  always #5 clk = ~clk;

  rvfi_reg_sweep_ctrl #(.CHECKS_PER_REG(CHECKS), .TIMEOUT(TMO), .FIRST_REG(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rvfi_valid(valid),
    .rvfi_rd_addr(rd_addr), .rvfi_rd_wdata(rd_wdata),
    .rvfi_rs1_addr(rs1_addr), .rvfi_rs1_rdata(rs1_rdata),
    .rvfi_rs2_addr(rs2_addr), .rvfi_rs2_rdata(rs2_rdata),
    .tgt_addr_o(tgt_addr), .tgt_written_o(tgt_written), .tgt_data_o(tgt_data),
    .err_rs1_o(err_rs1), .err_rs2_o(err_rs2), .err_sticky_o(err_sticky),
    .sweep_done_o(sweep_done)
  );

  task automatic model_update();
    bit h1, h2;
    m_e1 = 0; m_e2 = 0; m_done = 0;
    if (!rst_n) begin
      m_tgt = 1; m_valid = 0; m_adv = 0; m_data = '0;
      m_sticky = 0; m_checks = 0; m_idle = 0;
    end else if (m_adv) begin
      m_done  = (m_tgt == 31);
      m_tgt   = (m_tgt == 31) ? 1 : m_tgt + 1;
      m_adv   = 0; m_valid = 0; m_data = '0; m_checks = 0; m_idle = 0;
    end else if (valid) begin
      if (!m_valid) begin
        if (int'(rd_addr) == m_tgt) begin
          m_data = rd_wdata; m_valid = 1; m_checks = 0; m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle >= TMO) m_adv = 1;
        end
      end else begin
        h1 = (int'(rs1_addr) == m_tgt);
        h2 = (int'(rs2_addr) == m_tgt);
        m_e1 = h1 && (rs1_rdata != m_data);
        m_e2 = h2 && (rs2_rdata != m_data);
        m_sticky = m_sticky | m_e1 | m_e2;
        if (h1 || h2) begin m_checks++; m_idle = 0; end
        else m_idle++;
        if (int'(rd_addr) == m_tgt) m_data = rd_wdata;
        if (m_checks >= CHECKS || m_idle >= TMO) begin m_adv = 1; m_valid = 0; end
      end
    end
  endtask

  task automatic step(input bit v, input logic [4:0] rd, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [31:0] d1,
                      input logic [4:0] a2, input logic [31:0] d2);
    valid = v; rd_addr = rd; rd_wdata = wd;
    rs1_addr = a1; rs1_rdata = d1; rs2_addr = a2; rs2_rdata = d2;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_ret();
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 5'd0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, '0, '0, '0, '0, '0, '0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    step(1'b1, 5'd1, 32'h1234, 5'd0, '0, 5'd0, '0);
    do_reset();
    total++; if (tgt_addr !== 5'd1) $display("FAIL reset_tgt got %0d want 1", tgt_addr); else passed++;
    total++; if ({tgt_written, err_rs1, err_rs2, err_sticky, sweep_done} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {tgt_written, err_rs1, err_rs2, err_sticky, sweep_done}); else passed++;
    total++; if (tgt_data !== 32'h0) $display("FAIL reset_data got %h want 0", tgt_data); else passed++;
  endtask

  task automatic test_track_and_mismatch();
    do_reset();
    step(1'b1, 5'd1, 32'hDEADBEEF, 5'd0, '0, 5'd0, '0);
    step(1'b1, 5'd0, 32'h0, 5'd1, 32'hDEADBEEF, 5'd0, '0);
    total++; if (tgt_written !== 1'b1 || tgt_data !== 32'hDEADBEEF)
      $display("FAIL track_shadow got %b/%h want 1/deadbeef", tgt_written, tgt_data); else passed++;
    total++; if ({err_rs1, err_rs2, err_sticky} !== 3'b000)
      $display("FAIL track_noerr got %b want 000", {err_rs1, err_rs2, err_sticky}); else passed++;
    step(1'b1, 5'd0, 32'h0, 5'd0, '0, 5'd1, 32'h0);
    total++; if ({err_rs1, err_rs2, err_sticky} !== 3'b011)
      $display("FAIL rs2_mismatch got %b want 011", {err_rs1, err_rs2, err_sticky}); else passed++;
    step(1'b0, '0, '0, '0, '0, '0, '0);
    total++; if ({err_rs1, err_rs2, err_sticky} !== 3'b001)
      $display("FAIL rs2_pulse_end got %b want 001", {err_rs1, err_rs2, err_sticky}); else passed++;
  endtask

  task automatic test_advance_on_checks();
    do_reset();
    step(1'b1, 5'd1, 32'hA5, 5'd0, '0, 5'd0, '0);
    for (int i = 0; i < CHECKS; i++) begin
      // both sources hitting still counts as one check
      step(1'b1, 5'd0, '0, 5'd1, 32'hA5, 5'd1, 32'hA5);
      if (i == CHECKS - 2) begin
        total++; if (tgt_written !== 1'b1) $display("FAIL chk_still_track got %b want 1", tgt_written); else passed++;
      end
    end
    total++; if (tgt_written !== 1'b0 || tgt_addr !== 5'd1)
      $display("FAIL chk_adv_cycle got %b/%0d want 0/1", tgt_written, tgt_addr); else passed++;
    step(1'b1, 5'd2, 32'h77, 5'd0, '0, 5'd0, '0);
    total++; if (tgt_addr !== 5'd2 || tgt_written !== 1'b0)
      $display("FAIL chk_adv_next got %0d/%b want 2/0", tgt_addr, tgt_written); else passed++;
  endtask

  task automatic test_timeout_wrap();
    do_reset();
    for (int r = 1; r < 31; r++)
      for (int i = 0; i <= TMO; i++) idle_ret();
    total++; if (tgt_addr !== 5'd31) $display("FAIL timeout_reach31 got %0d want 31", tgt_addr); else passed++;
    for (int i = 0; i < TMO - 1; i++) idle_ret();
    total++; if (tgt_addr !== 5'd31 || sweep_done !== 1'b0)
      $display("FAIL timeout_early got %0d/%b want 31/0", tgt_addr, sweep_done); else passed++;
    idle_ret();
    idle_ret();
    total++; if (tgt_addr !== 5'd1 || sweep_done !== 1'b1)
      $display("FAIL wrap_done got %0d/%b want 1/1", tgt_addr, sweep_done); else passed++;
    idle_ret();
    total++; if (sweep_done !== 1'b0) $display("FAIL wrap_pulse got %b want 0", sweep_done); else passed++;
  endtask

  task automatic test_read_write_same_ret();
    do_reset();
    step(1'b1, 5'd1, 32'h11, 5'd0, '0, 5'd0, '0);
    step(1'b1, 5'd1, 32'h22, 5'd1, 32'h11, 5'd0, '0);
    total++; if (tgt_data !== 32'h22 || {err_rs1, err_rs2, err_sticky} !== 3'b000)
      $display("FAIL rw_same got %h/%b want 22/000", tgt_data, {err_rs1, err_rs2, err_sticky}); else passed++;
    for (int i = 0; i < CHECKS - 2; i++) step(1'b1, 5'd0, '0, 5'd0, '0, 5'd1, 32'h22);
    total++; if (tgt_written !== 1'b1) $display("FAIL rw_count_pre got %b want 1", tgt_written); else passed++;
    step(1'b1, 5'd0, '0, 5'd1, 32'h22, 5'd0, '0);
    total++; if (tgt_written !== 1'b0) $display("FAIL rw_count_adv got %b want 0", tgt_written); else passed++;
  endtask

  task automatic test_reset_mid_track();
    do_reset();
    for (int r = 1; r < 5; r++)
      for (int i = 0; i <= TMO; i++) idle_ret();
    step(1'b1, 5'd5, 32'h55, 5'd0, '0, 5'd0, '0);
    step(1'b1, 5'd0, '0, 5'd5, 32'h66, 5'd0, '0);
    total++; if (tgt_addr !== 5'd5 || {tgt_written, err_rs1, err_sticky} !== 3'b111)
      $display("FAIL x5_track got %0d/%b want 5/111", tgt_addr, {tgt_written, err_rs1, err_sticky}); else passed++;
    do_reset();
    total++; if (tgt_addr !== 5'd1 || {tgt_written, err_sticky} !== 2'b00 || tgt_data !== 32'h0)
      $display("FAIL mid_reset got %0d/%b/%h want 1/00/0", tgt_addr, {tgt_written, err_sticky}, tgt_data); else passed++;
  endtask

  task automatic test_random();
    logic [42:0] got, exp;
    logic [4:0]  rd, a1, a2;
    logic [31:0] d1, d2;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rd = ($urandom_range(1) == 0) ? 5'(m_tgt) : 5'($urandom_range(31));
      a1 = ($urandom_range(1) == 0) ? 5'(m_tgt) : 5'($urandom_range(31));
      a2 = ($urandom_range(2) == 0) ? 5'(m_tgt) : 5'($urandom_range(31));
      d1 = ($urandom_range(2) != 0) ? m_data : 32'($urandom_range(3));
      d2 = ($urandom_range(2) != 0) ? m_data : 32'($urandom_range(3));
      rst_n = ($urandom_range(499) != 0);
      step($urandom_range(9) < 7, rd, 32'($urandom_range(3)), a1, d1, a2, d2);
      got = {tgt_addr, tgt_written, tgt_data, err_rs1, err_rs2, err_sticky, sweep_done};
      exp = {5'(m_tgt), m_valid, m_data, m_e1, m_e2, m_sticky, m_done};
      total++;
      if (got !== exp) $display("FAIL random_cycle%0d got %h want %h", n, got, exp);
      else passed++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_track_and_mismatch();
    test_advance_on_checks();
    test_timeout_wrap();
    test_read_write_same_ret();
    test_reset_mid_track();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
